// File: rtl/conv_mac_pipeline.sv
// Pipelined TAPS-wide multiply / adder-tree / window-accumulate engine for convolution.
// Define CONV_SAT_EN to saturate results above 2^OW-1 and flag out_ovf; otherwise results wrap.
module conv_mac_pipeline #(
  parameter int TAPS      = 4,
  parameter int DW        = 4,
  parameter int WW        = 4,
  parameter int MAX_BEATS = 9,
  parameter int OW        = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [TAPS*DW-1:0]   In_IFM,
  input  logic [TAPS*WW-1:0]   In_Weight,
  output logic [OW-1:0]        Out_OFM,
  output logic                 out_valid,
  output logic                 out_ovf
);

  localparam int L  = $clog2(TAPS);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int PW = DW + WW;
  localparam int AW = PW + L + BW;

  logic               s0_v;
  logic               s0_last;
  logic [TAPS*DW-1:0] ifm_r;
  logic [TAPS*WW-1:0] wt_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and stage ordering cannot create races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v    <= 1'b0;
      s0_last <= 1'b0;
      ifm_r   <= '0;
      wt_r    <= '0;
    end else begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_last <= in_last;
        ifm_r   <= In_IFM;
        wt_r    <= In_Weight;
      end
    end
  end

  // Level 0 holds the products; level k holds TAPS>>k partial sums, each one bit wider.
  for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
    localparam int N = TAPS >> lv;
    localparam int W = PW + lv;
    logic         v;
    logic         last;
    logic [W-1:0] sum [N];

    if (lv == 0) begin : g_mul
      // NOTE: the operand arrays are reset as well, so no stale data survives a
      // mid-window reset; they are plain flops here, not RAM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v    <= 1'b0;
          last <= 1'b0;
          for (int j = 0; j < N; j++) sum[j] <= '0;
        end else begin
          v <= s0_v;
          if (s0_v) begin
            last <= s0_last;
            for (int j = 0; j < N; j++)
              sum[j] <= W'(ifm_r[j*DW +: DW]) * W'(wt_r[j*WW +: WW]);
          end
        end
      end
    end else begin : g_add
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v    <= 1'b0;
          last <= 1'b0;
          for (int j = 0; j < N; j++) sum[j] <= '0;
        end else begin
          v <= g_lvl[lv-1].v;
          if (g_lvl[lv-1].v) begin
            last <= g_lvl[lv-1].last;
            for (int j = 0; j < N; j++)
              sum[j] <= W'(g_lvl[lv-1].sum[2*j]) + W'(g_lvl[lv-1].sum[2*j+1]);
          end
        end
      end
    end
  end

  logic          acc_v;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic [BW-1:0] beat_cnt;
  logic          win_close;
  logic          done;
  logic [AW-1:0] res;

  assign acc_v = g_lvl[L].v;

  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    acc_sum   = acc + AW'(g_lvl[L].sum[0]);
    win_close = g_lvl[L].last || (beat_cnt == BW'(MAX_BEATS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      beat_cnt <= '0;
      res      <= '0;
      done     <= 1'b0;
    end else begin
      done <= acc_v && win_close;
      if (acc_v) begin
        if (win_close) begin
          res      <= acc_sum;
          acc      <= '0;
          beat_cnt <= '0;
        end else begin
          acc      <= acc_sum;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  // Range handling sits in its own stage so the accumulate adder stays off this path.
  logic [OW-1:0] ofm_next;
  logic          ovf_next;

  always_comb begin
`ifdef CONV_SAT_EN
    ovf_next = (res >> OW) != '0;
    ofm_next = ovf_next ? '1 : OW'(res);
`else
    ovf_next = 1'b0;
    ofm_next = OW'(res);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_OFM   <= '0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= done;
      if (done) begin
        Out_OFM <= ofm_next;
        out_ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipeline.sv
// Scoreboard bench for conv_mac_pipeline: directed plan scenarios plus random windows
// checked against a dot-product / window-sum reference model.
module tb_conv_mac_pipeline;

  localparam int TAPS      = 4;
  localparam int DW        = 4;
  localparam int WW        = 4;
  localparam int MAX_BEATS = 9;
  localparam int OW        = 12;
  localparam int LAT       = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_last;
  logic [TAPS*DW-1:0]   In_IFM;
  logic [TAPS*WW-1:0]   In_Weight;
  logic [OW-1:0]        Out_OFM;
  logic                 out_valid;
  logic                 out_ovf;

  conv_mac_pipeline #(
    .TAPS(TAPS), .DW(DW), .WW(WW), .MAX_BEATS(MAX_BEATS), .OW(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .In_IFM(In_IFM), .In_Weight(In_Weight),
    .Out_OFM(Out_OFM), .out_valid(out_valid), .out_ovf(out_ovf)
  );

  typedef struct {
    longint ofm;
    longint ovf;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  longint m_acc = 0;
  int     m_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: window value is the plain sum of per-beat dot products.
  task automatic push_result(input longint value);
    exp_t e;
`ifdef CONV_SAT_EN
    e.ofm = (value > (2**OW - 1)) ? (2**OW - 1) : value;
    e.ovf = (value > (2**OW - 1)) ? 1 : 0;
`else
    e.ofm = value % (2**OW);
    e.ovf = 0;
`endif
    e.cyc = cyc + 1 + LAT;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic v, input logic l,
                      input logic [TAPS*DW-1:0] ifm, input logic [TAPS*WW-1:0] wt);
    longint dot;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_last   = l;
    In_IFM    = ifm;
    In_Weight = wt;
    if (v) begin
      dot = 0;
      for (int i = 0; i < TAPS; i++) dot += longint'(ifm[i*DW +: DW]) * longint'(wt[i*WW +: WW]);
      m_acc += dot;
      m_cnt++;
      if (l || m_cnt == MAX_BEATS) begin
        push_result(m_acc);
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_pulse: out_valid=1 Out_OFM=%0d with nothing expected (cycle %0d)",
                 Out_OFM, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ofm", longint'(Out_OFM), e.ofm);
        check("ovf", longint'(out_ovf), e.ovf);
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    logic                 rv, rl;
    logic [TAPS*DW-1:0]   ri;
    logic [TAPS*WW-1:0]   rw;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    In_IFM    = '0;
    In_Weight = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ofm",   longint'(Out_OFM),   0);
    check("reset_valid", longint'(out_valid), 0);
    check("reset_ovf",   longint'(out_ovf),   0);
    rst_n = 1'b1;

    beat(1'b1, 1'b1, 16'h4321, 16'h8765);
    idle(8);

    for (int k = 1; k <= 4; k++) beat(1'b1, 1'b1, 16'h1111, 16'h1111 * k);
    idle(8);

    beat(1'b1, 1'b0, 16'h2222, 16'h3333);
    beat(1'b1, 1'b0, 16'h2222, 16'h3333);
    beat(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    beat(1'b1, 1'b1, 16'h2222, 16'h3333);
    idle(8);

    for (int k = 0; k < MAX_BEATS; k++) beat(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    beat(1'b1, 1'b1, 16'h1111, 16'h1111);
    idle(8);

    beat(1'b1, 1'b0, 16'h9999, 16'h7777);
    beat(1'b1, 1'b0, 16'h5555, 16'hAAAA);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_ofm",   longint'(Out_OFM),   0);
    check("midreset_valid", longint'(out_valid), 0);
    check("midreset_ovf",   longint'(out_ovf),   0);
    m_acc = 0;
    m_cnt = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    beat(1'b1, 1'b1, 16'h4321, 16'h8765);
    idle(10);

    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 3) == 0);
      ri = TAPS*DW'($urandom);
      rw = TAPS*WW'($urandom);
      beat(rv, rl, ri, rw);
    end
    beat(1'b1, 1'b1, 16'h1234, 16'h4321);
    idle(12);

    check("queue_drained", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipeline.md
# conv_mac_pipeline

Parametrised, fully pipelined multiply-accumulate engine for convolution windows. Each input beat carries TAPS IFM/weight pairs. The block multiplies them in parallel, reduces the products through a registered binary adder tree, and accumulates beats until a window closes, then emits one OFM value with a one-cycle valid pulse. It replaces the fixed 2x2 convolution pipeline and supports wider kernels, for example 3x3 split into 4-tap beats. Stage registers load only on valid data, keeping switching power low.

## Interface
- TAPS, 4, products per beat; power of 2, 2..16; L = log2(TAPS)
- DW, 4, unsigned IFM element width
- WW, 4, unsigned weight element width
- MAX_BEATS, 9, maximum beats per window, 1..64; BW = clog2(MAX_BEATS+1)
- OW, 12, output width; internal accumulator width AW = DW+WW+L+BW
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat present this cycle
- in_last  input  1  beat closes current window; qualified by in_valid
- In_IFM  input  TAPS*DW  tap i at bits [i*DW +: DW]
- In_Weight  input  TAPS*WW  tap i at bits [i*WW +: WW]
- Out_OFM  output  OW  window result, held between pulses
- out_valid  output  1  one-cycle pulse when Out_OFM updates
- out_ovf  output  1  result exceeded 2^OW-1; valid with out_valid

## Operation
- Stage S0 (input regs): captures In_IFM, In_Weight and in_last when in_valid=1.
- Stage S1: TAPS unsigned products, each DW+WW bits.
- Stages S2..S(L+1): one adder-tree level per stage. Each level widens by 1 bit, with no truncation.
- Stage S(L+2), accumulate/output stage:
  - On a valid beat, acc_next = acc + tree_sum, and beat_cnt increments.
  - The window closes if the beat's last tag is set or beat_cnt+1 == MAX_BEATS.
  - On close: Out_OFM <= result, out_valid <= 1, acc <= 0, beat_cnt <= 0.
- Every stage has a valid bit that shifts every cycle, regardless of in_valid. Data registers load only when their upstream valid bit is 1, otherwise they hold.
- The pipeline drains without further input. There is no backpressure, and a new beat is accepted every cycle.
- Gaps (in_valid=0) inside a window are allowed; acc and beat_cnt hold.
- Result width: AW bits internally; OW handling is set by the CONV_SAT_EN macro (see Configuration).
- A forced close at MAX_BEATS is the same as in_last. The next beat starts a new window.

## Timing
- Reset (asynchronous, any cycle, including mid-window): all valid bits, acc, beat_cnt and data registers are cleared to 0.
  - Out_OFM=0, out_valid=0, out_ovf=0.
  - In-flight beats are discarded.
  - The first beat after rst_n deasserts starts a new window.
- Latency is L+3 cycles, measured from the clk edge sampling the closing beat (in_valid=1) to the edge asserting out_valid. For TAPS=4 this is 5 cycles.
- Throughput: one beat per cycle; one result per cycle for back-to-back single-beat windows.
- out_valid is high for exactly one cycle per closed window. Out_OFM and out_ovf hold until the next close.
- A close and the first beat of the next window in consecutive cycles produce correct separate results. The accumulator clears on the close edge, and the next beat adds to 0.

## Configuration
- CONV_SAT_EN defined:
  - If the AW-bit result exceeds 2^OW-1, Out_OFM = 2^OW-1 (saturated) and out_ovf=1.
  - Otherwise the result is passed through and out_ovf=0.
- CONV_SAT_EN undefined:
  - Out_OFM = result mod 2^OW (wrap).
  - out_ovf is tied to 0, and no comparator is synthesised.

## Test plan
All scenarios use the default parameters.
- Single beat, IFM (1,2,3,4), weights (5,6,7,8), in_last=1 -> Out_OFM=70 with out_valid high for one cycle, 5 cycles after the sampling edge; out_ovf=0.
- Back-to-back single-beat windows: four beats with IFM all 1 and weights 1,2,3,4 on each tap, in_last=1 each beat -> results 4, 8, 12, 16 on four consecutive cycles.
- 3-beat window, with one in_valid=0 gap after beat 2; each beat IFM all 2, weights all 3; last on beat 3 -> single out_valid with Out_OFM=72; no pulse for the intermediate beats.
- 9 beats with all operands 15 and no in_last -> forced close after beat 9.
  - With CONV_SAT_EN: Out_OFM=4095, out_ovf=1.
  - Without CONV_SAT_EN: Out_OFM=4004 (8100 mod 4096), out_ovf=0.
  - A 10th beat (IFM all 1, weights all 1, last=1) -> separate result 4.
- Reset mid-operation: assert rst_n=0 after 2 beats of a window, with data still in flight -> outputs 0 immediately. After release, a single-beat window with IFM (1,2,3,4), weights (5,6,7,8) -> 70; no stale pulse or stale accumulation.
